mem_port_master: RTL and testbench
==================================

// Module: mem_port_master
// PURPOSE
//  Core-side initiator for one port of the shared 4-port byte data memory.
//  Accepts 16-bit word read/write requests from a multiplier core.
//  Writes issue one 16-bit store (low byte at addr, high byte at addr+1).
//  Reads fetch two consecutive bytes over the 8-bit registered read port and
//  assemble them little-endian. One instance sits between each core and its memory port.
// PARAMETERS
//  DATA_WIDTH  8  memory byte width; core word is 2*DATA_WIDTH
//  ADDR_WIDTH  8  memory address width
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  req         in   1       core request, sampled only when ready=1
//  req_we      in   1       1 = write, 0 = read
//  req_addr    in   AW      byte address of low byte
//  req_wdata   in   2*DW    write word; [DW-1:0] goes to addr, upper byte to addr+1
//  ready       out  1       block idle, will accept req this cycle
//  ack         out  1       one-cycle completion pulse
//  rdata       out  2*DW    read word; valid when ack=1 for a read, held until the next read ack
//  mem_we      out  1       to memory we[n]
//  mem_w_addr  out  AW      to memory w_addr
//  mem_w_data  out  2*DW    to memory w_data
//  mem_r_addr  out  AW      to memory r_addr
//  mem_r_data  in   DW      from memory r_data (registered, 1-cycle latency, updated only when mem_we=0)
// BEHAVIOUR
//  - FSM states: IDLE, WR, RD_LO, RD_HI, RD_CAP. ready = (state==IDLE) & !rst.
//  - Accept at cycle T (IDLE & req): latch addr, we and wdata into addr_q, we_q and wdata_q.
//    Next state is WR if we, otherwise RD_LO. Request inputs are ignored in every other state.
//  - WR (T+1): mem_we=1, mem_w_addr=addr_q, mem_w_data=wdata_q. Then IDLE; ack=1 at T+2.
//  - RD_LO (T+1): mem_r_addr=addr_q, mem_we=0.
//  - RD_HI (T+2): mem_r_addr=addr_q+1; capture mem_r_data into rdata_lo at end of cycle.
//  - RD_CAP (T+3): capture mem_r_data into rdata_hi. Then IDLE; ack=1 and rdata={hi,lo} at T+4.
//  - Latency req->ack: write 2 cycles, read 4 cycles.
//  - Back-to-back: the ack cycle is IDLE, so a new req is accepted in that same cycle.
//  - addr_q+1 wraps modulo 2**ADDR_WIDTH (0xFF -> 0x00), matching the memory's write wrap.
//  - mem_we is combinational from state, gated by !rst. mem_we is 0 outside WR.
//  - mem_w_addr, mem_w_data and mem_r_addr are driven from addr_q/wdata_q in all states.
//  - Reset, any cycle: state=IDLE, ack=0, rdata=0, addr_q=0, wdata_q=0, we_q=0, mem_we=0.
//    A reset asserted during WR performs no write. An in-flight read is abandoned with no ack.
//  - Read-after-write to the same address by this port returns the new data, since the write
//    commits at the end of WR before RD_LO can begin.
// CONFIGURATION
//  BYTE_MODE_EN defined:
//    - Adds input port req_byte (1 bit), latched at accept.
//    - A read with req_byte=1 goes RD_LO -> RD_CAP, capturing the byte in RD_CAP and skipping RD_HI.
//      ack comes at T+3 with rdata={DW'b0, byte}.
//    - req_byte is ignored for writes; writes always store 2 bytes.
//  BYTE_MODE_EN undefined: req_byte port absent; every read is a 16-bit, 4-cycle read.
// TESTING
//  1. Default memory init, read addr 0x00 -> ack at T+4, rdata=16'h0302 (mem[0]=2, mem[1]=3).
//  2. Write 16'hBEEF @0x10 -> mem_we high exactly 1 cycle, ack at T+2.
//     Then read @0x10 -> rdata=16'hBEEF.
//  3. Wrap: write 16'h1234 @0xFF -> mem[0xFF]=8'h34, mem[0x00]=8'h12.
//     Read @0xFF -> mem_r_addr sequence 0xFF, 0x00; rdata=16'h1234.
//  4. Back-to-back: read @0x08 with req held high through the ack cycle.
//     First ack rdata=16'h460A; second request accepted in the ack cycle; no idle gap.
//  5. Reset during RD_HI -> next cycle ready=1, ack=0, rdata=0, no ack for the aborted read.
//     Reset during WR -> mem_we=0 and target bytes unchanged.
//  6. BYTE_MODE_EN: byte read @0x0B -> ack at T+3, rdata=16'h0002.
//     Without the macro the same read returns 16'h0302 at T+4.

Source files
------------

// File: rtl/mem_port_master.sv
// Core-side initiator for one port of the shared byte memory: 16-bit word writes, 2-byte little-endian reads.
// Optional `BYTE_MODE_EN adds req_byte for single-byte reads that skip the high-byte fetch.
module mem_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
`ifdef BYTE_MODE_EN
  input  logic                    req_byte,
`endif
  output logic                    ready,
  output logic                    ack,
  output logic [2*DATA_WIDTH-1:0] rdata,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_LO,
    RD_HI,
    RD_CAP
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [2*DATA_WIDTH-1:0]   wdata_q;
  logic                      we_q;
  logic [DATA_WIDTH-1:0]     rdata_lo;
  logic                      byte_rd;
  logic                      accept;

  // High-byte address wraps modulo 2**ADDR_WIDTH, same as the memory's write path.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] zext_byte(input logic [DATA_WIDTH-1:0] b);
    return {{DATA_WIDTH{1'b0}}, b};
  endfunction

`ifdef BYTE_MODE_EN
  logic byte_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= 1'b0;
    end else if (accept) begin
      byte_q <= req_byte;
    end
  end

  assign byte_rd = byte_q;
`else
  assign byte_rd = 1'b0;
`endif

  assign ready  = (state_q == IDLE) & ~rst;
  assign accept = ready & req;

  assign mem_we     = (state_q == WR) & we_q & ~rst;
  assign mem_w_addr = addr_q;
  assign mem_w_data = wdata_q;
  assign mem_r_addr = (state_q == RD_HI) ? addr_inc(addr_q) : addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = req_we ? WR : RD_LO;
      WR:      state_d = IDLE;
      RD_LO:   state_d = byte_rd ? RD_CAP : RD_HI;
      RD_HI:   state_d = RD_CAP;
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept stage: request fields are only sampled while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end
    end
  end

  // Capture stage: memory read data lags its address by one cycle, so the low byte
  // arrives in RD_HI and the high (or single) byte in RD_CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= 1'b0;
      rdata    <= '0;
      rdata_lo <= '0;
    end else begin
      ack <= (state_q == WR) | (state_q == RD_CAP);
      if (state_q == RD_HI) begin
        rdata_lo <= mem_r_data;
      end
      if (state_q == RD_CAP) begin
        rdata <= byte_rd ? zext_byte(mem_r_data) : {mem_r_data, rdata_lo};
      end
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Scoreboard bench for mem_port_master with a behavioural byte memory on the port.
module tb_mem_port_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
`ifdef BYTE_MODE_EN
  logic        req_byte;
`endif
  logic        ready;
  logic        ack;
  logic [15:0] rdata;
  logic        mem_we;
  logic [7:0]  mem_w_addr;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_r_addr;
  logic [7:0]  mem_r_data;

  always #5 clk = ~clk;

  mem_port_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef BYTE_MODE_EN
    .req_byte   (req_byte),
`endif
    .ready      (ready),
    .ack        (ack),
    .rdata      (rdata),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  logic [7:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 2);
    mem[8'h08] = 8'h0A;
    mem[8'h09] = 8'h46;
    mem[8'h0B] = 8'h02;
    mem[8'h0C] = 8'h03;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_w_addr]        <= mem_w_data[7:0];
      mem[mem_w_addr + 8'd1] <= mem_w_data[15:8];
    end else begin
      mem_r_data <= mem[mem_r_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t sbq[$];

  int          we_cnt = 0;
  logic [7:0]  last_wa;
  logic [15:0] last_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_wa = mem_w_addr;
      last_wd = mem_w_data;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack: ack at cycle %0d with rdata %h, expected no ack", cyc, rdata);
      end else begin
        e = sbq.pop_front();
        check("ack_cycle", cyc, e.at);
        if (e.is_rd) check("rdata", rdata, e.data);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready=%b, expected 1", ready);
    end
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_data, input int lat);
    exp_t e;
    wait_ready();
    req       = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    e.is_rd = ~we;
    e.data  = exp_data;
    e.at    = cyc + lat;
    sbq.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    rst       = 1'b1;
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
`ifdef BYTE_MODE_EN
    req_byte  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready, 1);

    // Plain read from initial memory contents
    issue(1'b0, 8'h00, 16'h0000, 16'h0302, 4);
    drain();

    // Write then read back
    we_cnt = 0;
    issue(1'b1, 8'h10, 16'hBEEF, 16'h0000, 2);
    drain();
    check("wr_we_cycles", we_cnt, 1);
    check("wr_addr", last_wa, 8'h10);
    check("wr_data", last_wd, 16'hBEEF);
    check("mem10", mem[8'h10], 8'hEF);
    check("mem11", mem[8'h11], 8'hBE);
    issue(1'b0, 8'h10, 16'h0000, 16'hBEEF, 4);
    drain();

    // Address wrap at the top of memory
    issue(1'b1, 8'hFF, 16'h1234, 16'h0000, 2);
    drain();
    check("memFF", mem[8'hFF], 8'h34);
    check("mem00", mem[8'h00], 8'h12);
    issue(1'b0, 8'hFF, 16'h0000, 16'h1234, 4);
    @(negedge clk);
    check("rd_lo_addr", mem_r_addr, 8'hFF);
    @(negedge clk);
    check("rd_hi_addr", mem_r_addr, 8'h00);
    drain();

    // Back-to-back: req held through the ack cycle; address changed while busy
    wait_ready();
    req      = 1'b1;
    req_we   = 1'b0;
    req_addr = 8'h08;
    e.is_rd = 1'b1;
    e.data  = 16'h460A;
    e.at    = cyc + 4;
    sbq.push_back(e);
    e.data  = 16'h0312;
    e.at    = cyc + 8;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_addr = 8'h00;
    repeat (4) @(posedge clk);
    #1 req = 1'b0;
    drain();

    // Reset during RD_HI abandons the read
    issue(1'b0, 8'h10, 16'h0000, 16'hBEEF, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_ack", ack, 0);
    check("abort_rdata", rdata, 0);
    repeat (6) @(negedge clk);

    // Reset during WR suppresses the write
    we_cnt = 0;
    issue(1'b1, 8'h20, 16'hAAAA, 16'h0000, 2);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("wr_rst_mem_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wr_rst_ready", ready, 1);
    check("wr_rst_ack", ack, 0);
    repeat (4) @(negedge clk);
    check("wr_rst_we_cycles", we_cnt, 0);
    check("mem20", mem[8'h20], 8'h22);
    check("mem21", mem[8'h21], 8'h23);

    // Byte read (or full word read when byte mode is not built)
`ifdef BYTE_MODE_EN
    req_byte = 1'b1;
    issue(1'b0, 8'h0B, 16'h0000, 16'h0002, 3);
    req_byte = 1'b0;
    drain();
`else
    issue(1'b0, 8'h0B, 16'h0000, 16'h0302, 4);
    drain();
`endif
    issue(1'b0, 8'h0B, 16'h0000, 16'h0302, 4);
    drain();

    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
